pll_reset_ctrl: RTL and testbench
=================================

// Module: pll_reset_ctrl
// PURPOSE
//  Reset/lock sequencer for the 12 MHz PLL.
//  - Runs on the 50 MHz reference clock.
//  - Drives the PLL's active-low reset and watches its asynchronous locked output.
//  - Releases the system reset only after lock has been stable for a set time.
//  - Retries on lock timeout and re-sequences on loss of lock.
//  - Sits between board reset and the FIR datapath reset tree.
// PARAMETERS
//  RST_PULSE_CYC     16     cycles pll_rst_n held low per PLL reset attempt (>=1)
//  LOCK_TIMEOUT_CYC  50000  cycles allowed in WAIT_LOCK before a retry (1 ms @ 50 MHz)
//  STABLE_CYC        1024   consecutive locked cycles required before release
//  MAX_RETRY         3      timeouts tolerated before entering FAIL
//  CNT_W             8      width of lol_cnt
// PORTS
//  refclk      in   1      50 MHz reference clock; only clock
//  rst         in   1      asynchronous, active-high reset
//  pll_locked  in   1      PLL locked flag; asynchronous to refclk
//  restart     in   1      1-cycle pulse; forces a full new PLL sequence
//  pll_rst_n   out  1      active-low PLL reset; connects to PLL wrapper rst
//  sys_rst     out  1      active-high reset for downstream logic
//  ready       out  1      1 only in RUN
//  fail        out  1      1 only in FAIL
//  retry_cnt   out  2      timeouts in the current sequence
//  lol_cnt     out  CNT_W  loss-of-lock events in RUN; saturating
// BEHAVIOUR
//  Reset values:
//   - state=PLL_RST, pll_rst_n=0, sys_rst=1, ready=0, fail=0.
//   - retry_cnt=0, lol_cnt=0, all timers=0.
//  All outputs are registered.
//  pll_locked passes through a 2-flop synchronizer (locked_s); 2-cycle latency.
//  States:
//   PLL_RST:
//    - pll_rst_n=0 for exactly RST_PULSE_CYC cycles.
//    - Then -> WAIT_LOCK with the timer cleared.
//   WAIT_LOCK:
//    - pll_rst_n=1.
//    - locked_s=1 -> STABLE.
//    - Else, timer reaches LOCK_TIMEOUT_CYC-1:
//      - retry_cnt==MAX_RETRY -> FAIL.
//      - Otherwise retry_cnt+1 and -> PLL_RST.
//   STABLE:
//    - Counts consecutive locked_s=1 cycles.
//    - Count reaches STABLE_CYC -> RUN.
//    - locked_s=0 -> WAIT_LOCK: timeout timer restarts; this is not a retry.
//   RUN:
//    - sys_rst=0 and ready=1, registered on the RUN entry edge.
//    - locked_s=0 -> lol_cnt+1 (holds at all-ones), retry_cnt=0, -> PLL_RST.
//    - sys_rst=1 and ready=0 on that same edge.
//   FAIL:
//    - pll_rst_n=0, sys_rst=1, fail=1.
//    - Held until restart or rst.
//  restart has top priority in every state:
//   - -> PLL_RST, retry_cnt=0, fail=0, sys_rst=1, ready=0.
//   - lol_cnt is kept.
//  sys_rst=1 in every state except RUN.
//  ready and fail are never both 1.
//  rst asserted mid-sequence: immediate asynchronous return to the reset values.
//  Deassertion of rst takes effect on the next refclk edge.
// TESTING (sim params: RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=20, STABLE_CYC=8, MAX_RETRY=2)
//  1. Release rst; pll_locked rises 5 cycles after pll_rst_n rises.
//     -> pll_rst_n low exactly 4 cycles.
//     -> sys_rst falls 2+8(+1) cycles after pll_locked rises; ready=1, fail=0.
//  2. pll_locked held 0 -> three 20-cycle waits, each preceded by a 4-cycle pll_rst_n pulse.
//     -> retry_cnt 0,1,2; then fail=1, pll_rst_n=0, sys_rst=1.
//  3. In RUN, drop pll_locked for 3 cycles.
//     -> lol_cnt=1, sys_rst=1, ready=0.
//     -> New 4-cycle pll_rst_n pulse; re-lock returns to RUN.
//  4. In STABLE, glitch pll_locked low 1 cycle at count 5.
//     -> Back to WAIT_LOCK, retry_cnt unchanged.
//     -> Full 8 stable cycles are needed again.
//  5. In FAIL, pulse restart.
//     -> fail=0, retry_cnt=0, pll_rst_n low 4 cycles.
//     -> Normal lock reaches RUN; lol_cnt preserved.
//  6. Assert rst asynchronously mid-STABLE and mid-RUN.
//     -> Outputs go to reset values without a clock edge.
//     -> Force 300 losses of lock with CNT_W=8: lol_cnt saturates at 255.

Source files
------------

// File: rtl/pll_reset_ctrl.sv
// Reset/lock sequencer for the PLL: pulses the PLL reset, waits for a stable lock,
// then releases the downstream system reset; retries on timeout, re-sequences on loss of lock.
module pll_reset_ctrl #(
    parameter int unsigned RST_PULSE_CYC    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
    parameter int unsigned STABLE_CYC       = 1024,
    parameter int unsigned MAX_RETRY        = 3,
    parameter int unsigned CNT_W            = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             restart,
    output logic             pll_rst_n,
    output logic             sys_rst,
    output logic             ready,
    output logic             fail,
    output logic [1:0]       retry_cnt,
    output logic [CNT_W-1:0] lol_cnt
);

    localparam int unsigned T_MAX0 = (RST_PULSE_CYC > STABLE_CYC) ? RST_PULSE_CYC : STABLE_CYC;
    localparam int unsigned T_MAX  = (LOCK_TIMEOUT_CYC > T_MAX0) ? LOCK_TIMEOUT_CYC : T_MAX0;
    localparam int unsigned TW     = (T_MAX <= 2) ? 1 : $clog2(T_MAX);

    localparam logic [TW-1:0] PULSE_LAST   = TW'(RST_PULSE_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYC - 1);
    localparam logic [1:0]    RETRY_MAX    = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t             state_q;
    logic [TW-1:0]      timer_q;
    logic [1:0]         retry_cnt_q;
    logic [CNT_W-1:0]   lol_cnt_q;
    logic               pll_rst_n_q;
    logic               sys_rst_q;
    logic               ready_q;
    logic               fail_q;
    logic               sync_meta_q;
    logic               locked_s_q;

    // pll_locked comes from the PLL's own clock domain
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_meta_q <= 1'b0;
            locked_s_q  <= 1'b0;
        end else begin
            sync_meta_q <= pll_locked;
            locked_s_q  <= sync_meta_q;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_PLL_RST;
            timer_q     <= '0;
            retry_cnt_q <= '0;
            lol_cnt_q   <= '0;
            pll_rst_n_q <= 1'b0;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else if (restart) begin
            state_q     <= S_PLL_RST;
            timer_q     <= '0;
            retry_cnt_q <= '0;
            pll_rst_n_q <= 1'b0;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            case (state_q)
                S_PLL_RST: begin
                    if (timer_q == PULSE_LAST) begin
                        state_q     <= S_WAIT_LOCK;
                        timer_q     <= '0;
                        pll_rst_n_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s_q) begin
                        state_q <= S_STABLE;
                        timer_q <= '0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        timer_q     <= '0;
                        pll_rst_n_q <= 1'b0;
                        if (retry_cnt_q == RETRY_MAX) begin
                            state_q <= S_FAIL;
                            fail_q  <= 1'b1;
                        end else begin
                            state_q     <= S_PLL_RST;
                            retry_cnt_q <= retry_cnt_q + 2'd1;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_STABLE: begin
                    // a single unlocked cycle restarts the lock wait, not a retry
                    if (!locked_s_q) begin
                        state_q <= S_WAIT_LOCK;
                        timer_q <= '0;
                    end else if (timer_q == STABLE_LAST) begin
                        state_q   <= S_RUN;
                        timer_q   <= '0;
                        sys_rst_q <= 1'b0;
                        ready_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_RUN: begin
                    if (!locked_s_q) begin
                        state_q     <= S_PLL_RST;
                        timer_q     <= '0;
                        retry_cnt_q <= '0;
                        pll_rst_n_q <= 1'b0;
                        sys_rst_q   <= 1'b1;
                        ready_q     <= 1'b0;
                        if (lol_cnt_q != '1) begin
                            lol_cnt_q <= lol_cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_FAIL: begin
                    pll_rst_n_q <= 1'b0;
                    sys_rst_q   <= 1'b1;
                    ready_q     <= 1'b0;
                    fail_q      <= 1'b1;
                end
                default: begin
                    state_q     <= S_PLL_RST;
                    timer_q     <= '0;
                    pll_rst_n_q <= 1'b0;
                    sys_rst_q   <= 1'b1;
                    ready_q     <= 1'b0;
                    fail_q      <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst_n = pll_rst_n_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_cnt_q;
    assign lol_cnt   = lol_cnt_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: phase-based reference model feeds a scoreboard queue,
// a monitor compares every cycle; directed scenarios plus randomized lock behaviour.
module tb_pll_reset_ctrl;

    localparam int unsigned RST_PULSE = 4;
    localparam int unsigned TIMEOUT   = 20;
    localparam int unsigned STABLE_N  = 8;
    localparam int unsigned MAXR      = 2;
    localparam int unsigned CW        = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pll_locked = 1'b0;
    logic          restart = 1'b0;
    logic          pll_rst_n, sys_rst, ready, fail;
    logic [1:0]    retry_cnt;
    logic [CW-1:0] lol_cnt;

    pll_reset_ctrl #(
        .RST_PULSE_CYC    (RST_PULSE),
        .LOCK_TIMEOUT_CYC (TIMEOUT),
        .STABLE_CYC       (STABLE_N),
        .MAX_RETRY        (MAXR),
        .CNT_W            (CW)
    ) dut (
        .refclk     (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst_n  (pll_rst_n),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .lol_cnt    (lol_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          prn;
        logic          srst;
        logic          rdy;
        logic          fl;
        logic [1:0]    rc;
        logic [CW-1:0] lol;
    } out_t;

    out_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_no = 0;
    bit   running = 0;

    // Reference model: phase name, cycles elapsed in the phase, retries, losses,
    // and the last two sampled pll_locked values (synchronizer delay).
    string ph;
    int    el, retries, losses;
    bit    h1, h2;

    task automatic model_reset();
        ph = "PULSE"; el = 0; retries = 0; losses = 0; h1 = 0; h2 = 0;
    endtask

    task automatic model_step(input bit lk, input bit rs);
        bit ls;
        ls = h2; h2 = h1; h1 = lk;
        if (rs) begin
            ph = "PULSE"; el = 0; retries = 0;
        end else if (ph == "PULSE") begin
            el++;
            if (el == RST_PULSE) begin ph = "WAIT"; el = 0; end
        end else if (ph == "WAIT") begin
            if (ls) begin
                ph = "STABLE"; el = 0;
            end else begin
                el++;
                if (el == TIMEOUT) begin
                    el = 0;
                    if (retries == MAXR) ph = "FAIL";
                    else begin retries++; ph = "PULSE"; end
                end
            end
        end else if (ph == "STABLE") begin
            if (!ls) begin
                ph = "WAIT"; el = 0;
            end else begin
                el++;
                if (el == STABLE_N) begin ph = "RUN"; el = 0; end
            end
        end else if (ph == "RUN") begin
            if (!ls) begin
                if (losses < (1 << CW) - 1) losses++;
                retries = 0; ph = "PULSE"; el = 0;
            end
        end
    endtask

    function automatic out_t model_out();
        out_t o;
        o.prn  = !(ph == "PULSE" || ph == "FAIL");
        o.srst = (ph != "RUN");
        o.rdy  = (ph == "RUN");
        o.fl   = (ph == "FAIL");
        o.rc   = 2'(retries);
        o.lol  = CW'(losses);
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // One refclk cycle of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic cyc(input bit r, input bit lk, input bit rs);
        rst = r; pll_locked = lk; restart = rs;
        if (r) model_reset();
        else model_step(lk, rs);
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic run_n(input int n, input bit lk);
        for (int i = 0; i < n; i++) cyc(0, lk, 0);
    endtask

    task automatic async_reset_check(input string tag);
        #3; rst = 1'b1; #1;
        check({tag, "_prn"},   pll_rst_n, 0);
        check({tag, "_srst"},  sys_rst,   1);
        check({tag, "_ready"}, ready,     0);
        check({tag, "_fail"},  fail,      0);
        check({tag, "_retry"}, retry_cnt, 0);
        check({tag, "_lol"},   lol_cnt,   0);
    endtask

    out_t mon_e, mon_a;
    always @(posedge clk) begin
        #2;
        if (running) begin
            cyc_no++;
            mon_a = {pll_rst_n, sys_rst, ready, fail, retry_cnt, lol_cnt};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty at cycle %0d", cyc_no);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_a !== mon_e) begin
                    n_bad++;
                    $display("FAIL cycle_%0d: got prn=%b srst=%b rdy=%b fail=%b retry=%0d lol=%0d, required prn=%b srst=%b rdy=%b fail=%b retry=%0d lol=%0d",
                             cyc_no, mon_a.prn, mon_a.srst, mon_a.rdy, mon_a.fl, mon_a.rc, mon_a.lol,
                             mon_e.prn, mon_e.srst, mon_e.rdy, mon_e.fl, mon_e.rc, mon_e.lol);
                end
            end
        end
    end

    bit lv;
    int len;

    initial begin
        model_reset();
        running = 1;
        #1;
        for (int i = 0; i < 3; i++) cyc(1, 0, 0);
        check("reset_prn",   pll_rst_n, 0);
        check("reset_srst",  sys_rst,   1);
        check("reset_ready", ready,     0);
        check("reset_fail",  fail,      0);
        check("reset_retry", retry_cnt, 0);
        check("reset_lol",   lol_cnt,   0);

        // Power-up sequence: 4-cycle PLL reset, lock 5 cycles after release
        run_n(3, 0);
        check("t1_prn_still_low", pll_rst_n, 0);
        run_n(1, 0);
        check("t1_prn_released", pll_rst_n, 1);
        run_n(4, 0);
        run_n(10, 1);
        check("t1_not_yet_run", ready, 0);
        run_n(1, 1);
        check("t1_ready", ready, 1);
        check("t1_srst", sys_rst, 0);
        check("t1_fail", fail, 0);
        run_n(3, 1);

        // Loss of lock in RUN for 3 cycles
        run_n(3, 0);
        check("t3_lol", lol_cnt, 1);
        check("t3_srst", sys_rst, 1);
        check("t3_ready", ready, 0);
        check("t3_prn", pll_rst_n, 0);
        run_n(20, 1);
        check("t3_relock", ready, 1);

        // Lock glitch while STABLE count is at 5
        cyc(0, 1, 1);
        for (int i = 1; i <= 18; i++) cyc(0, (i != 9), 0);
        check("t4_still_stable", ready, 0);
        check("t4_retry", retry_cnt, 0);
        run_n(2, 1);
        check("t4_run", ready, 1);

        // Lock never arrives: three timeouts then FAIL
        cyc(0, 0, 1);
        run_n(79, 0);
        check("t2_fail", fail, 1);
        check("t2_retry", retry_cnt, 2);
        check("t2_prn", pll_rst_n, 0);
        check("t2_srst", sys_rst, 1);
        check("t2_ready", ready, 0);

        // restart out of FAIL
        cyc(0, 0, 1);
        check("t5_fail_clr", fail, 0);
        check("t5_retry_clr", retry_cnt, 0);
        check("t5_prn", pll_rst_n, 0);
        run_n(20, 1);
        check("t5_run", ready, 1);
        check("t5_lol_kept", lol_cnt, 1);

        // Asynchronous reset mid-RUN and mid-STABLE
        async_reset_check("t6_run");
        cyc(1, 1, 0); cyc(1, 1, 0);
        run_n(7, 1);
        async_reset_check("t6_stable");
        cyc(1, 1, 0); cyc(1, 1, 0);
        run_n(20, 1);
        check("t6_recover", ready, 1);

        // Randomized lock behaviour with occasional restarts
        for (int blk = 0; blk < 60; blk++) begin
            lv  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 40);
            for (int k = 0; k < len; k++) cyc(0, lv, ($urandom_range(0, 63) == 0));
        end

        // 300 losses of lock: counter saturates
        cyc(0, 1, 1);
        run_n(16, 1);
        for (int n = 0; n < 300; n++) begin
            run_n(1, 0);
            run_n(16, 1);
        end
        check("t6_lol_sat", lol_cnt, 255);
        check("t6_sat_ready", ready, 1);

        running = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
